// File: rtl/msg_checker_pkg.sv
// Shared definitions for the message checker.
// Holds the scan FSM state type, the legal-character bounds, the largest supported message
// length and the character legality test used by the checker.

package msg_checker_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } state_t;

    localparam logic [7:0]  CHAR_SPACE  = 8'h20;
    localparam logic [7:0]  CHAR_LO     = 8'h61;
    localparam logic [7:0]  CHAR_HI     = 8'h7A;
    localparam int unsigned MSG_LEN_MAX = 32;
    localparam int unsigned IDX_W       = 5;

    // A byte is legal when it is a space or a lower-case letter.
    function automatic logic is_legal_char(input logic [7:0] c);
        return (c == CHAR_SPACE) || ((c >= CHAR_LO) && (c <= CHAR_HI));
    endfunction

endpackage

// File: rtl/msg_checker_if.sv
// Control and RAM-read bundle of the message checker.
// Ports (master = checker side):
//   start      request to scan
//   address_d  read address to the decrypted-message RAM
//   q_d        read data from the decrypted-message RAM
//   busy       scan in progress
//   done       one-cycle completion pulse
//   valid      last scan found only legal bytes
//   bad_index  index of the first illegal byte of the last scan
//   bad_char   value of the first illegal byte of the last scan

interface msg_checker_if;
    import msg_checker_pkg::*;

    logic             start;
    logic [IDX_W-1:0] address_d;
    logic [7:0]       q_d;
    logic             busy;
    logic             done;
    logic             valid;
    logic [IDX_W-1:0] bad_index;
    logic [7:0]       bad_char;

    modport master (
        input  start,
        input  q_d,
        output address_d,
        output busy,
        output done,
        output valid,
        output bad_index,
        output bad_char
    );

    modport slave (
        output start,
        output q_d,
        input  address_d,
        input  busy,
        input  done,
        input  valid,
        input  bad_index,
        input  bad_char
    );

endinterface

// File: rtl/msg_rd_pipe.sv
// Tag pipeline matching RAM read latency.
// Carries a valid bit and a byte index RD_LAT cycles so each RAM read word arrives together
// with the index of the address that produced it.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   flush         synchronous clear of all in-flight tags
//   in_valid      an address is being issued this cycle
//   in_index      the index of that address
//   out_valid     the RAM data on q_d this cycle belongs to a tagged read
//   out_index     index of that read
//   active        any tag still in flight

module msg_rd_pipe
    import msg_checker_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_index,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic             active
);

    logic [RD_LAT-1:0]            vld_q;
    logic [RD_LAT-1:0][IDX_W-1:0] idx_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            idx_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            idx_q[0] <= in_index;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_index = idx_q[RD_LAT-1];
    assign active    = |vld_q;

endmodule

// File: rtl/msg_checker.sv
// Decrypted-message checker.
// On an accepted start, reads MSG_LEN bytes from a RAM with RD_LAT cycles of read latency and
// reports whether every byte is a space or a lower-case letter; the first offending byte and
// its index are kept until the next accepted start.
// Optional feature: define MSG_CHECKER_EARLY_EXIT_EN to stop reading at the first illegal byte
// and finish one cycle after it is sampled.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      msg_checker_if master: start, address_d, q_d, busy, done, valid, bad_index,
//            bad_char

module msg_checker
    import msg_checker_pkg::*;
#(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    msg_checker_if.master bus
);

`ifdef MSG_CHECKER_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    localparam logic [IDX_W-1:0] LastAddr = IDX_W'(MSG_LEN - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic             bad_seen_q, bad_seen_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] bad_index_q, bad_index_d;
    logic [7:0]       bad_char_q, bad_char_d;

    logic             tag_in_valid;
    logic             tag_out_valid;
    logic [IDX_W-1:0] tag_out_index;
    logic             tags_active;
    logic             abort;
    logic             sample_en;
    logic             sample_bad;
    logic             accept;

    // With early exit, a recorded illegal byte halts issue and discards later samples.
    assign abort      = EarlyExit && bad_seen_q;
    assign accept     = (state_q == StIdle) && bus.start;
    assign sample_en  = ((state_q == StRead) || (state_q == StDrain)) && tag_out_valid && !abort;
    assign sample_bad = sample_en && !is_legal_char(bus.q_d);
    assign tag_in_valid = (state_q == StRead) && !abort;

    msg_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (state_q == StDone),
        .in_valid  (tag_in_valid),
        .in_index  (addr_q),
        .out_valid (tag_out_valid),
        .out_index (tag_out_index),
        .active    (tags_active)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StRead;
            end
            StRead: begin
                if (abort)                  state_d = StDone;
                else if (addr_q == LastAddr) state_d = StDrain;
            end
            StDrain: begin
                // Done once the last tagged read has been sampled.
                if (abort || !tags_active) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.address_d = '0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        unique case (state_q)
            StIdle: ;
            StRead: begin
                bus.busy = 1'b1;
                if (!abort) bus.address_d = addr_q;
            end
            StDrain: bus.busy = 1'b1;
            StDone:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state
    always_comb begin
        addr_d      = (state_q == StRead) ? addr_q + IDX_W'(1) : '0;
        bad_seen_d  = bad_seen_q;
        valid_d     = valid_q;
        bad_index_d = bad_index_q;
        bad_char_d  = bad_char_q;
        if (accept) begin
            bad_seen_d  = 1'b0;
            valid_d     = 1'b0;
            bad_index_d = '0;
            bad_char_d  = '0;
        end else if (sample_bad && !bad_seen_q) begin
            bad_seen_d  = 1'b1;
            bad_index_d = tag_out_index;
            bad_char_d  = bus.q_d;
        end
        // DONE is only entered with no sample pending, so bad_seen_q is final here.
        if ((state_q != StDone) && (state_d == StDone)) begin
            valid_d = !bad_seen_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            bad_seen_q  <= 1'b0;
            valid_q     <= 1'b0;
            bad_index_q <= '0;
            bad_char_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            bad_seen_q  <= bad_seen_d;
            valid_q     <= valid_d;
            bad_index_q <= bad_index_d;
            bad_char_q  <= bad_char_d;
        end
    end

    assign bus.valid     = valid_q;
    assign bus.bad_index = bad_index_q;
    assign bus.bad_char  = bad_char_q;

endmodule

// File: tb/tb_msg_checker.sv
// Self-checking bench for msg_checker: one instance with RD_LAT=1, one with RD_LAT=3, each with
// a behavioural RAM of matching latency. Expected scan results go into a scoreboard queue when
// a scan is started and are popped when the done pulse appears.

module tb_msg_checker;

`ifdef MSG_CHECKER_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    localparam int MsgLen = 32;
    localparam int Budget = 60;

    typedef struct {
        logic       valid;
        logic [4:0] idx;
        logic [7:0] chr;
        int         done_at;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
    logic [7:0] mem1 [MsgLen];
    logic [7:0] mem3 [MsgLen];
    logic [7:0] q1, r3a, r3b, q3;
    logic sel3 = 1'b0;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    msg_checker_if bus1 ();
    msg_checker_if bus3 ();

    assign bus1.start = start1;
    assign bus3.start = start3;
    assign bus1.q_d   = q1;
    assign bus3.q_d   = q3;

    msg_checker #(.MSG_LEN(32), .RD_LAT(1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    msg_checker #(.MSG_LEN(32), .RD_LAT(3)) u_dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    // Synchronous-read RAM models
    always @(posedge clk) begin
        q1  <= mem1[bus1.address_d];
        r3a <= mem3[bus3.address_d];
        r3b <= r3a;
        q3  <= r3b;
    end

    logic [4:0] o_addr, o_bidx;
    logic [7:0] o_bchr;
    logic       o_busy, o_done, o_valid;
    assign o_addr  = sel3 ? bus3.address_d : bus1.address_d;
    assign o_busy  = sel3 ? bus3.busy      : bus1.busy;
    assign o_done  = sel3 ? bus3.done      : bus1.done;
    assign o_valid = sel3 ? bus3.valid     : bus1.valid;
    assign o_bidx  = sel3 ? bus3.bad_index : bus1.bad_index;
    assign o_bchr  = sel3 ? bus3.bad_char  : bus1.bad_char;

    function automatic logic legal(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7a));
    endfunction

    function automatic logic [7:0] get_byte(input int lat, input int i);
        return (lat == 3) ? mem3[i] : mem1[i];
    endfunction

    task automatic drive_start(input int lat, input logic v);
        if (lat == 3) start3 = v;
        else          start1 = v;
    endtask

    task automatic fill(input int lat, input logic [7:0] v);
        for (int i = 0; i < MsgLen; i++) begin
            if (lat == 3) mem3[i] = v;
            else          mem1[i] = v;
        end
    endtask

    // One scan; inject > 0 holds start high across edge E(inject) as an extra request.
    task automatic run_scan(input int lat, input int inject, input string tag);
        exp_t e, got;
        int   k, n, last_issue, exp_addr, addr_bad_n, busy_bad_n;
        logic seen_done;
        logic [4:0] addr_bad_v;
        sel3 = (lat == 3);
        k = -1;
        for (int i = 0; i < MsgLen; i++) begin
            if (k < 0 && !legal(get_byte(lat, i))) k = i;
        end
        e.valid = (k < 0);
        e.idx   = (k < 0) ? 5'd0 : 5'(k);
        e.chr   = (k < 0) ? 8'h00 : get_byte(lat, k);
        e.done_at = (EarlyExit && k >= 0) ? k + 2 + lat : MsgLen + lat + 1;
        last_issue = (EarlyExit && k >= 0 && k + lat < MsgLen - 1) ? k + lat : MsgLen - 1;
        sb.push_back(e);

        @(negedge clk);
        drive_start(lat, 1'b1);
        n = 0;
        seen_done = 1'b0;
        addr_bad_n = -1;
        addr_bad_v = '0;
        busy_bad_n = -1;
        while (!seen_done && n < Budget) begin
            @(posedge clk);
            #1;
            exp_addr = (n <= last_issue) ? n : 0;
            if (o_addr !== 5'(exp_addr) && addr_bad_n < 0) begin
                addr_bad_n = n;
                addr_bad_v = o_addr;
            end
            if (o_done === 1'b1) begin
                seen_done = 1'b1;
                got = sb.pop_front();
                n_cmp++;
                if (n !== got.done_at) begin
                    n_bad++;
                    $display("FAIL %s done_edge: got E%0d want E%0d", tag, n, got.done_at);
                end
                n_cmp++;
                if (o_valid !== got.valid) begin
                    n_bad++;
                    $display("FAIL %s valid: got %b want %b", tag, o_valid, got.valid);
                end
                n_cmp++;
                if (o_bidx !== got.idx) begin
                    n_bad++;
                    $display("FAIL %s bad_index: got %0d want %0d", tag, o_bidx, got.idx);
                end
                n_cmp++;
                if (o_bchr !== got.chr) begin
                    n_bad++;
                    $display("FAIL %s bad_char: got %h want %h", tag, o_bchr, got.chr);
                end
                n_cmp++;
                if (o_busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s busy_in_done: got %b want 0", tag, o_busy);
                end
            end else begin
                if (o_busy !== 1'b1 && busy_bad_n < 0) busy_bad_n = n;
                n++;
                drive_start(lat, inject == n);
            end
        end
        n_cmp++;
        if (!seen_done) begin
            n_bad++;
            $display("FAIL %s done_timeout: got none in %0d edges want E%0d", tag, Budget,
                     e.done_at);
            void'(sb.pop_front());
        end
        n_cmp++;
        if (addr_bad_n >= 0) begin
            n_bad++;
            $display("FAIL %s address_d: got %0d after E%0d want %0d", tag, addr_bad_v,
                     addr_bad_n, (addr_bad_n <= last_issue) ? addr_bad_n : 0);
        end
        n_cmp++;
        if (busy_bad_n >= 0) begin
            n_bad++;
            $display("FAIL %s busy: got 0 after E%0d want 1", tag, busy_bad_n);
        end
        // Cycle after DONE: pulse gone, result held, a start sampled in DONE not queued.
        drive_start(lat, inject == n + 1);
        @(posedge clk);
        #1;
        drive_start(lat, 1'b0);
        n_cmp++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_valid !== e.valid) begin
            n_bad++;
            $display("FAIL %s after_done: got done=%b busy=%b valid=%b want 0 0 %b", tag,
                     o_done, o_busy, o_valid, e.valid);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s start_queued: got busy=%b want 0", tag, o_busy);
        end
    endtask

    task automatic test_reset();
        #3;
        for (int d = 0; d < 2; d++) begin
            sel3 = (d == 1);
            #1;
            n_cmp++;
            if ({o_addr, o_busy, o_done, o_valid, o_bidx, o_bchr} !== 21'd0) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d: got addr=%0d busy=%b done=%b valid=%b idx=%0d chr=%h want all 0",
                         d, o_addr, o_busy, o_done, o_valid, o_bidx, o_bchr);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_legal();
        fill(1, 8'h61);
        run_scan(1, 0, "all_legal");
    endtask

    task automatic test_two_bad();
        fill(1, 8'h61);
        mem1[5]  = 8'h41;
        mem1[20] = 8'h7b;
        run_scan(1, 0, "two_bad");
    endtask

    task automatic test_first_byte_bad();
        fill(1, 8'h61);
        mem1[0] = 8'h41;
        run_scan(1, 0, "first_bad");
    endtask

    task automatic test_boundaries();
        logic [7:0] ok_vals [3];
        logic [7:0] bad_vals [3];
        int         bad_pos [3];
        ok_vals  = '{8'h20, 8'h61, 8'h7a};
        bad_vals = '{8'h21, 8'h60, 8'h7b};
        bad_pos  = '{3, 17, 31};
        for (int i = 0; i < MsgLen; i++) mem1[i] = ok_vals[i % 3];
        run_scan(1, 0, "bound_pass");
        for (int j = 0; j < 3; j++) begin
            fill(1, 8'h20);
            mem1[bad_pos[j]] = bad_vals[j];
            run_scan(1, 0, $sformatf("bound_fail_%h", bad_vals[j]));
        end
    endtask

    task automatic test_start_ignored();
        fill(1, 8'h7a);
        run_scan(1, 5, "start_while_busy");
        run_scan(1, MsgLen + 3, "start_in_done");
    endtask

    task automatic test_reset_abort();
        int dones;
        sel3 = 1'b0;
        fill(1, 8'h61);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_addr !== 5'd0 || o_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abort_async: got busy=%b valid=%b addr=%0d done=%b want 0 0 0 0",
                     o_busy, o_valid, o_addr, o_done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (o_done === 1'b1 || o_busy === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++;
            $display("FAIL reset_abort_resume: got %0d cycles of done/busy want 0", dones);
        end
        run_scan(1, 0, "after_reset");
    endtask

    task automatic test_lat3();
        fill(3, 8'h61);
        run_scan(3, 0, "lat3_legal");
        mem3[9] = 8'h7b;
        run_scan(3, 0, "lat3_bad");
    endtask

    initial begin
        fill(1, 8'h00);
        fill(3, 8'h00);
        test_reset();
        test_all_legal();
        test_two_bad();
        test_first_byte_bad();
        test_boundaries();
        test_start_ignored();
        test_reset_abort();
        test_lat3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test want finish before 1 ms");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msg_checker.md
MSG_CHECKER -- requirements
Module: msg_checker

Interface
REQ-001 Parameter MSG_LEN, default 32, is the number of message bytes scanned; the legal range is 2..32.
REQ-002 Parameter RD_LAT, default 1, is the read latency of the decrypted-message RAM in cycles, counted from address driven to q valid; the legal range is 1..3.
REQ-003 clk  in  1  system clock; every flop samples on the rising edge.
REQ-004 reset_n  in  1  asynchronous reset, active-low.
REQ-005 start  in  1  request to scan; sampled on a rising edge.
REQ-006 address_d  out  5  read address to the decrypted-message RAM.
REQ-007 q_d  in  8  read data from the decrypted-message RAM.
REQ-008 busy  out  1  high while a scan is in progress.
REQ-009 done  out  1  one-cycle pulse marking scan completion.
REQ-010 valid  out  1  result of the last scan: all checked bytes were legal.
REQ-011 bad_index  out  5  index of the first illegal byte in the last scan.
REQ-012 bad_char  out  8  value of the first illegal byte in the last scan.

Function
REQ-013 A byte is legal iff it is 8'h20 (space) or lies in 8'h61..8'h7A (a-z), inclusive.
REQ-014 The FSM has four states: IDLE, READ, DRAIN, DONE.
REQ-015 In IDLE, address_d=0 and busy=0; start=1 at edge E0 moves to READ and sets busy=1.
REQ-016 The edge that accepts start clears valid, bad_index and bad_char to 0.
REQ-017 In READ, address_d=k in cycle k+1 after E0, for k=0..MSG_LEN-1; one address is issued per cycle with no gaps.
REQ-018 After address MSG_LEN-1 is issued, the FSM enters DRAIN and address_d returns to 0.
REQ-019 Byte k is sampled from q_d at edge E(k+1+RD_LAT); an internal valid/index tag pipeline RD_LAT deep associates each sample with its index.
REQ-020 The first illegal byte sampled loads bad_index and bad_char; later illegal bytes do not overwrite them.
REQ-021 With no early exit, DONE is entered at edge E(MSG_LEN+RD_LAT+1); for the defaults this is E34.
REQ-022 In DONE, done=1 for exactly one cycle; valid=1 iff no illegal byte was seen; busy=0; the next state is IDLE.
REQ-023 valid, bad_index and bad_char hold their values until the next accepted start or until reset.
REQ-024 A start asserted while busy=1 or while in DONE is ignored and is not queued.
REQ-025 q_d is ignored in every cycle that has no tagged sample.

Reset
REQ-026 When reset_n=0, the block enters IDLE asynchronously.
REQ-027 During reset: address_d=0, busy=0, done=0, valid=0, bad_index=0, bad_char=0, and the tag pipeline is cleared.
REQ-028 A reset during READ or DRAIN abandons the scan with no done pulse; in-flight read data is discarded.
REQ-029 The first start after reset_n rises is accepted normally.

Configuration
REQ-030 The macro MSG_CHECKER_EARLY_EXIT_EN controls early exit.
- Defined: when illegal byte k is sampled, further address issue stops; the block enters DONE at E(k+2+RD_LAT) with valid=0; later samples are discarded.
- Undefined: every scan covers all MSG_LEN bytes, per REQ-021.

Structure
REQ-031 A shared package msg_checker_pkg holds:
- the state enum type;
- constants CHAR_SPACE=8'h20, CHAR_LO=8'h61, CHAR_HI=8'h7A;
- MSG_LEN_MAX=32.
REQ-032 The tag pipeline is one sub-module, msg_rd_pipe (a parameterised RD_LAT-deep shift register carrying the valid bit and the 5-bit index); all other logic is in msg_checker.

Verification
REQ-033 RAM of 32x 8'h61, defaults, start at E0 -> address_d steps 0..31 in cycles 1..32; done pulses at E34; valid=1; busy high E0..E34.
REQ-034 Byte 5=8'h41 and byte 20=8'h7B, macro undefined -> done at E34, valid=0, bad_index=5, bad_char=8'h41.
REQ-035 Byte 0=8'h41, macro defined -> done at E3, valid=0, bad_index=0, bad_char=8'h41, no address>1 issued.
REQ-036 Boundary bytes 8'h20, 8'h61, 8'h7A pass; 8'h21, 8'h60, 8'h7B each fail in separate runs with the correct bad_index.
REQ-037 Second start pulse at E5 -> ignored; reset_n=0 at E10 -> busy=0, valid=0 before the next edge, no done pulse; a new start after reset completes with done at E34 relative to its own accepting edge.
REQ-038 RD_LAT=3, all legal bytes -> done at E36, valid=1.
